chime_sequencer: RTL
====================

// Module: chime_sequencer
// PURPOSE
// - Upstream stage of the doorbell chime: turns a raw push-button into a two-tone "ding-dong".
// - Generates square-wave sounds tone_a/tone_b and the sel line that drive the doorbell output multiplexer.
// - Debounces the button, sequences DING (sel=0, sound a) then DONG (sel=1, sound b), then flags completion.
// PARAMETERS
// - DEBOUNCE_CYCLES  4   consecutive stable synced samples needed to change the debounced level
// - DING_CYCLES      16  clock cycles spent in DING (sel=0)
// - DONG_CYCLES      24  clock cycles spent in DONG (sel=1)
// - DIV_A            2   half-period of tone_a in cycles (period 2*DIV_A)
// - DIV_B            3   half-period of tone_b in cycles (period 2*DIV_B)
// - CNT_W            8   width of all internal counters; every parameter is >=1 and <2**CNT_W
// PORTS
// - clk     in   1  single clock, all flops on rising edge
// - rst_n   in   1  synchronous, active-low reset
// - button  in   1  raw asynchronous push-button, high = pressed
// - tone_a  out  1  "ding" square wave, feeds mux input a
// - tone_b  out  1  "dong" square wave, feeds mux input b
// - sel     out  1  mux select: 0 = tone_a, 1 = tone_b
// - busy    out  1  high while a chime is playing (DING or DONG)
// - done    out  1  one-cycle pulse when a chime completes normally
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): state IDLE, all counters and sync/debounce flops 0; tone_a=tone_b=sel=busy=done=0.
// - Reset mid-chime aborts immediately: no done pulse, outputs 0 after that edge.
// - Sync: two-flop synchroniser on button -> btn_s.
// - Debounce: counter increments while btn_s differs from debounced level deb, clears to 0 when equal;
//   on reaching DEBOUNCE_CYCLES, deb toggles and counter clears. Pulses shorter than DEBOUNCE_CYCLES are ignored.
// - Press event = deb rising (deb=1, previous deb=0). Holding the button never retriggers; release+re-press required.
// - Latency: edge 0 is the first edge sampling button=1 (held stable); deb rises after edge DEBOUNCE_CYCLES+1,
//   busy rises after edge DEBOUNCE_CYCLES+2 (edge 6 for defaults).
// - FSM states: IDLE, DING, DONG.
//   IDLE: busy=0, sel=0; press event -> DING, duration counter cleared.
//   DING: busy=1, sel=0; exactly DING_CYCLES cycles, then -> DONG.
//   DONG: busy=1, sel=1; exactly DONG_CYCLES cycles, then -> IDLE.
//   done=1 for the single cycle after the last DONG cycle (first IDLE cycle); otherwise 0.
// - Press events while busy are dropped (no queueing); a press event coincident with the done cycle starts a new chime.
// - sel, busy, done are registered outputs (no combinational path from button).
// - Tone generators run only while busy: on entry to DING, both divider counters and tones clear to 0;
//   tone_x toggles when its counter reaches DIV_X-1 (counter then wraps to 0). Counters continue across DING->DONG.
// - In IDLE tone_a=tone_b=0 and divider counters held at 0.
// - Duration counter: counts 0..N-1 in each playing state, wraps to 0 on state change; no overflow for legal N.
// TESTING
// - Reset: rst_n=0 for 3 cycles with button=1 -> all outputs 0; after rst_n=1 with button held, chime starts at edge 6.
// - Clean press (defaults): button high 10 cycles -> busy after edge 6, sel=0 for 16 cycles, sel=1 for 24, done pulse 1 cycle, busy=0.
// - Glitch: button high 3 cycles then low -> busy, sel, done stay 0 for 100 cycles.
// - Tones: during DING tone_a pattern 0,0,1,1,0,0...; tone_b 0,0,0,1,1,1...; both 0 in IDLE.
// - Re-press during DONG (release then press 10 cycles) -> ignored, exactly one done pulse; next press after done plays full chime.
// - Reset mid-DONG at cycle 30 of chime -> outputs 0 next edge, no done; later press plays full 40-cycle chime.

Source files
------------

// File: rtl/chime_sequencer_if.sv
// ----------------------------------------------------------------------------
// chime_sequencer_if
// Bundles the doorbell chime signals: the raw push-button going into the
// sequencer and the tone/select/status lines coming out of it.
//   button : raw asynchronous push-button, high = pressed
//   tone_a : "ding" square wave (mux input a)
//   tone_b : "dong" square wave (mux input b)
//   sel    : mux select, 0 = tone_a, 1 = tone_b
//   busy   : high while a chime is playing
//   done   : one-cycle pulse when a chime completes normally
// master = the side that drives the button (board / bench)
// slave  = the chime sequencer itself
// ----------------------------------------------------------------------------
interface chime_sequencer_if;
    logic button;
    logic tone_a;
    logic tone_b;
    logic sel;
    logic busy;
    logic done;

    modport master (
        output button,
        input  tone_a,
        input  tone_b,
        input  sel,
        input  busy,
        input  done
    );

    modport slave (
        input  button,
        output tone_a,
        output tone_b,
        output sel,
        output busy,
        output done
    );
endinterface

// File: rtl/chime_sequencer.sv
// ----------------------------------------------------------------------------
// chime_sequencer
// Turns a raw push-button into a two-tone "ding-dong": the button is
// synchronised and debounced, a press starts DING (sel=0, tone_a) followed by
// DONG (sel=1, tone_b), and a one-cycle done pulse marks normal completion.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : chime_sequencer_if.slave (button in; tone_a, tone_b, sel, busy,
//           done out -- all outputs come straight from flops)
// ----------------------------------------------------------------------------
module chime_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DING_CYCLES     = 16,
    parameter int unsigned DONG_CYCLES     = 24,
    parameter int unsigned DIV_A           = 2,
    parameter int unsigned DIV_B           = 3,
    parameter int unsigned CNT_W           = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    chime_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DING = 2'd1,
        ST_DONG = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DING_LAST = CNT_W'(DING_CYCLES - 1);
    localparam logic [CNT_W-1:0] DONG_LAST = CNT_W'(DONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIVA_LAST = CNT_W'(DIV_A - 1);
    localparam logic [CNT_W-1:0] DIVB_LAST = CNT_W'(DIV_B - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic             deb_prev_r;
    logic [CNT_W-1:0] deb_cnt_r;
    logic             press_s;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] dur_r;
    logic [CNT_W-1:0] dur_s;
    logic             done_s;

    logic [CNT_W-1:0] div_a_r;
    logic [CNT_W-1:0] div_a_s;
    logic [CNT_W-1:0] div_b_r;
    logic [CNT_W-1:0] div_b_s;
    logic             tone_a_r;
    logic             tone_a_s;
    logic             tone_b_r;
    logic             tone_b_s;

    logic             sel_r;
    logic             busy_r;
    logic             done_r;

    // Two-flop synchroniser followed by the debounce counter and level history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            deb_r      <= 1'b0;
            deb_prev_r <= 1'b0;
            deb_cnt_r  <= '0;
        end else begin
            sync1_r    <= bus.button;
            sync2_r    <= sync1_r;
            deb_prev_r <= deb_r;
            if (sync2_r == deb_r) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r == DEB_LAST) begin
                // This sample is the DEBOUNCE_CYCLES-th consecutive disagreement.
                deb_r     <= ~deb_r;
                deb_cnt_r <= '0;
            end else begin
                deb_cnt_r <= deb_cnt_r + ONE;
            end
        end
    end

    // Only a rising debounced level counts, so a held button never retriggers.
    assign press_s = deb_r & ~deb_prev_r;

    // Next-state, duration counter and completion decode for the chime FSM.
    always_comb begin
        state_s = state_r;
        dur_s   = dur_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                dur_s = '0;
                if (press_s) begin
                    state_s = ST_DING;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DING: begin
                if (dur_r == DING_LAST) begin
                    state_s = ST_DONG;
                    dur_s   = '0;
                end else begin
                    dur_s   = dur_r + ONE;
                end
            end
            ST_DONG: begin
                if (dur_r == DONG_LAST) begin
                    state_s = ST_IDLE;
                    dur_s   = '0;
                    done_s  = 1'b1;
                end else begin
                    dur_s   = dur_r + ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                dur_s   = '0;
            end
        endcase
    end

    // Tone dividers: cleared while idle and on the entry edge into DING,
    // otherwise free-running straight through the DING->DONG boundary.
    always_comb begin
        div_a_s  = div_a_r;
        div_b_s  = div_b_r;
        tone_a_s = tone_a_r;
        tone_b_s = tone_b_r;
        if ((state_s == ST_IDLE) || (state_r == ST_IDLE)) begin
            div_a_s  = '0;
            div_b_s  = '0;
            tone_a_s = 1'b0;
            tone_b_s = 1'b0;
        end else begin
            if (div_a_r == DIVA_LAST) begin
                div_a_s  = '0;
                tone_a_s = ~tone_a_r;
            end else begin
                div_a_s  = div_a_r + ONE;
            end
            if (div_b_r == DIVB_LAST) begin
                div_b_s  = '0;
                tone_b_s = ~tone_b_r;
            end else begin
                div_b_s  = div_b_r + ONE;
            end
        end
    end

    // State, counters and the registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            dur_r    <= '0;
            div_a_r  <= '0;
            div_b_r  <= '0;
            tone_a_r <= 1'b0;
            tone_b_r <= 1'b0;
            sel_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            dur_r    <= dur_s;
            div_a_r  <= div_a_s;
            div_b_r  <= div_b_s;
            tone_a_r <= tone_a_s;
            tone_b_r <= tone_b_s;
            sel_r    <= (state_s == ST_DONG);
            busy_r   <= (state_s != ST_IDLE);
            done_r   <= done_s;
        end
    end

    assign bus.tone_a = tone_a_r;
    assign bus.tone_b = tone_b_r;
    assign bus.sel    = sel_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule
